sr_pulse_gen: RTL and testbench

- Upstream command stage for the SR latch: converts clocked set/clear requests into clean, mutually exclusive S and R pulses.
- Pulse width is fixed and programmable, followed by a dead-time guard, so the latch never sees S=R=1.
- Keeps a shadow copy of the latch state the driven pulses should produce, for checking against the latch's Q.

---
 rtl/sr_pulse_pkg.sv | 22 ++
 rtl/sr_pulse_timer.sv | 29 ++
 rtl/sr_pulse_gen.sv | 120 ++++++++++++
 tb/tb_sr_pulse_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_pulse_pkg.sv
// Shared types and defaults for the SR latch pulse generator.
// Optional conflict counter: SR_PULSE_GEN_CONFLICT_CNT_EN.
package sr_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SET_P,
        CLR_P,
        GUARD
    } sr_pulse_state_t;

    localparam int PULSE_W_DEF = 4;
    localparam int GUARD_W_DEF = 2;
    localparam int CNT_W_DEF   = 8;

    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the pulse and guard phases.
// Holds at zero until the next load.
module sr_pulse_timer
    import sr_pulse_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sr_pulse_gen.sv
// Converts set/clear requests into exclusive, timed S/R pulses with guard.
// Optional conflict counter: SR_PULSE_GEN_CONFLICT_CNT_EN.
module sr_pulse_gen
    import sr_pulse_pkg::*;
#(
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int GUARD_W = GUARD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_req,
    input  logic             clr_req,
    output logic             S,
    output logic             R,
    output logic             busy,
    output logic             done,
    output logic             q_track,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int TW = timer_w(PULSE_W, GUARD_W);
    localparam logic [TW-1:0] PW_LD = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] GW_LD = TW'(GUARD_W - 1);

    sr_pulse_state_t state_q, state_d;
    logic            s_d, r_d, busy_d, done_d, q_d;
    logic            t_load, t_zero;
    logic [TW-1:0]   t_val;

    sr_pulse_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_d = state_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        q_d     = q_track;
        t_load  = 1'b0;
        t_val   = PW_LD;
        unique case (state_q)
            IDLE: begin
                if (set_req && !clr_req) begin
                    state_d = SET_P;
                    s_d     = 1'b1;
                    busy_d  = 1'b1;
                    t_load  = 1'b1;
                end else if (clr_req && !set_req) begin
                    state_d = CLR_P;
                    r_d     = 1'b1;
                    busy_d  = 1'b1;
                    t_load  = 1'b1;
                end
            end
            SET_P, CLR_P: begin
                busy_d = 1'b1;
                if (t_zero) begin
                    state_d = GUARD;
                    t_load  = 1'b1;
                    t_val   = GW_LD;
                    q_d     = (state_q == SET_P);
                end else begin
                    s_d = (state_q == SET_P);
                    r_d = (state_q == CLR_P);
                end
            end
            GUARD: begin
                busy_d = 1'b1;
                if (t_zero) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            S       <= 1'b0;
            R       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q_track <= 1'b0;
        end else begin
            state_q <= state_d;
            S       <= s_d;
            R       <= r_d;
            busy    <= busy_d;
            done    <= done_d;
            q_track <= q_d;
        end
    end

`ifdef SR_PULSE_GEN_CONFLICT_CNT_EN
    logic conflict;
    assign conflict = (state_q == IDLE) && set_req && clr_req;

    // Saturating: once full it stays full until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Bench for sr_pulse_gen: cycle-offset model plus directed and random stimulus.
// Honours SR_PULSE_GEN_CONFLICT_CNT_EN for counter expectations.
module tb_sr_pulse_gen;

    localparam int PW = 4;
    localparam int GW = 2;
`ifdef SR_PULSE_GEN_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       S, R, busy, done, q_track;
    logic [7:0] conflict_cnt;
    logic       s2, r2, busy2, done2, q2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_pulse_gen #(.PULSE_W(PW), .GUARD_W(GW), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .S(S), .R(R), .busy(busy), .done(done), .q_track(q_track),
        .conflict_cnt(conflict_cnt)
    );

    sr_pulse_gen #(.PULSE_W(PW), .GUARD_W(GW), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
        .S(s2), .R(r2), .busy(busy2), .done(done2), .q_track(q2),
        .conflict_cnt(cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: outputs follow from the cycle offset since the accepted command
    int e = 0;
    int ks = 0;
    bit active = 0;
    bit kind = 0;
    bit seen = 0;
    bit m_s, m_r, m_busy, m_done, m_q;
    int m_cnt = 0;
    int m_cnt2 = 0;

    always @(posedge clk) begin
        int d;
        e++;
        if (!rst_n) begin
            active = 0;
            m_q    = 0;
            m_cnt  = 0;
            m_cnt2 = 0;
            seen   = 1;
        end else if (!active || (e - ks >= PW + GW + 1)) begin
            if (set_req ^ clr_req) begin
                active = 1;
                ks     = e;
                kind   = set_req;
            end else if (set_req && clr_req && CNT_EN) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        d      = e + 1 - ks;
        m_s    = active && kind && d >= 1 && d <= PW;
        m_r    = active && !kind && d >= 1 && d <= PW;
        m_busy = active && d >= 1 && d <= PW + GW;
        m_done = active && d == PW + GW + 1;
        if (active && d == PW + 1) m_q = kind;
    end

    always @(negedge clk) begin
        if (seen) begin
            chk("S", S, m_s);
            chk("R", R, m_r);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("q_track", q_track, m_q);
            chk("conflict_cnt", conflict_cnt, m_cnt);
            chk("sat_cnt", cnt2, m_cnt2);
            chk("sat_S", s2, m_s);
            chk("sat_R", r2, m_r);
            chk("sat_busy", busy2, m_busy);
            chk("sat_done", done2, m_done);
            chk("sat_q", q2, m_q);
            chk("s_r_excl", S & R, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q_track, 0);
        chk("rst_cnt", conflict_cnt, 0);

        set_req = 1'b1;
        step();
        set_req = 1'b0;
        chk("set_k1_S", S, 1);
        repeat (3) step();
        chk("set_k4_S", S, 1);
        step();
        chk("set_k5_S", S, 0);
        chk("set_k5_busy", busy, 1);
        chk("set_k5_q", q_track, 1);
        step();
        chk("set_k6_busy", busy, 1);
        step();
        chk("set_k7_done", done, 1);
        chk("set_k7_busy", busy, 0);
        step();
        chk("set_k8_done", done, 0);

        clr_req = 1'b1;
        step();
        chk("clr_k1_R", R, 1);
        chk("clr_k1_q", q_track, 1);
        repeat (4) step();
        chk("clr_k5_R", R, 0);
        chk("clr_k5_q", q_track, 0);
        repeat (2) step();
        chk("clr_k7_done", done, 1);
        chk("clr_k7_R", R, 0);
        step();
        chk("clr_k8_R", R, 1);
        clr_req = 1'b0;
        repeat (12) step();

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req = 1'b1;
        clr_req = 1'b1;
        repeat (3) step();
        set_req = 1'b0;
        clr_req = 1'b0;
        chk("conf3_cnt", conflict_cnt, CNT_EN ? 3 : 0);
        chk("conf3_sat", cnt2, CNT_EN ? 3 : 0);
        chk("conf3_busy", busy, 0);
        set_req = 1'b1;
        clr_req = 1'b1;
        repeat (2) step();
        set_req = 1'b0;
        clr_req = 1'b0;
        step();
        chk("conf5_cnt", conflict_cnt, CNT_EN ? 5 : 0);
        chk("conf5_sat", cnt2, CNT_EN ? 3 : 0);
        chk("conf5_S", S, 0);

        set_req = 1'b1;
        step();
        set_req = 1'b0;
        repeat (9) step();
        chk("pre_rst_q", q_track, 1);
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        repeat (2) step();
        chk("mid_k3_S", S, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_S", S, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_q", q_track, 0);
        rst_n = 1'b1;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("post_k1_R", R, 1);
        repeat (3) step();
        chk("post_k4_R", R, 1);
        step();
        chk("post_k5_R", R, 0);
        repeat (5) step();

        for (int i = 0; i < 10000; i++) begin
            set_req = ($urandom_range(0, 3) == 0);
            clr_req = ($urandom_range(0, 3) == 0);
            rst_n   = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
